// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, functs, next-PC selects,
// immediate-extension kinds and the default reserved-instruction code.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    typedef enum logic [1:0] {
        EXT_SIGN,
        EXT_ZERO,
        EXT_LUI
    } extOp_e;

    localparam int EXC_RI_DEF = 10;

endpackage

// File: rtl/id_decode.sv
// Control decode for ID: next-PC select, immediate kind, jump flag
// and reserved-instruction detection from opcode/funct/rt fields.
import mips_pkg::*;

module id_decode (
    input  logic [5:0] op,
    input  logic [4:0] rt,
    input  logic [5:0] funct,
    input  logic       rsEqRt,
    input  logic       rsLtz,
    input  logic       rsEqz,
    output logic [1:0] npcOp,
    output extOp_e     extOp,
    output logic       isJump,
    output logic       undef
);

    logic isSpecial, isRegimm, isJmp, isBr;
    logic isLogicI, isLui, isPlainI;
    logic functOk, isJr, brTaken;

    assign isSpecial = op == OP_SPECIAL;
    assign isRegimm  = op == OP_REGIMM;
    assign isJmp     = op inside {OP_J, OP_JAL};
    assign isBr      = op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
    assign isLogicI  = op inside {OP_ANDI, OP_ORI, OP_XORI};
    assign isLui     = op == OP_LUI;
    assign isPlainI  = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                                  OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
                                  OP_SB, OP_SH, OP_SW};

    assign isJr    = funct inside {F_JR, F_JALR};
    assign functOk = funct inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV,
                                   F_SRAV, F_JR, F_JALR, F_SLT, F_SLTU,
                                   [F_ADD:F_NOR]};

    always_comb begin
        brTaken = 1'b0;
        case (op)
            OP_BEQ:    brTaken = rsEqRt;
            OP_BNE:    brTaken = !rsEqRt;
            OP_BLEZ:   brTaken = rsLtz || rsEqz;
            OP_BGTZ:   brTaken = !(rsLtz || rsEqz);
            OP_REGIMM: brTaken = (rt == RT_BGEZ) ? !rsLtz : rsLtz;
            default:   brTaken = 1'b0;
        endcase
    end

    always_comb begin
        npcOp  = NPC_SEQ;
        extOp  = EXT_SIGN;
        isJump = 1'b0;
        undef  = 1'b0;
        unique case (1'b1)
            isSpecial: begin
                undef = !functOk;
                if (isJr) begin
                    npcOp  = NPC_JR;
                    isJump = 1'b1;
                end
            end
            isRegimm: begin
                if (rt inside {RT_BLTZ, RT_BGEZ}) begin
                    isJump = 1'b1;
                    npcOp  = brTaken ? NPC_BR : NPC_SEQ;
                end else begin
                    undef = 1'b1;
                end
            end
            isJmp: begin
                npcOp  = NPC_J;
                isJump = 1'b1;
            end
            isBr: begin
                isJump = 1'b1;
                npcOp  = brTaken ? NPC_BR : NPC_SEQ;
            end
            isLogicI: extOp = EXT_ZERO;
            isLui:    extOp = EXT_LUI;
            isPlainI: extOp = EXT_SIGN;
            default:  undef = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: bypassed register file, branch/jump resolution,
// exception merge, delay-slot tracking and the ID/EX pipeline register.
import mips_pkg::*;

module id_stage_pipe #(
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int EXC_W  = 5,
    parameter  int EXC_RI = EXC_RI_DEF,
    localparam int AW     = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [31:0]      instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [EXC_W-1:0] exc_i,
    input  logic [XLEN-1:0]  fwd_rd1_i,
    input  logic [XLEN-1:0]  fwd_rd2_i,
    input  logic             rf_we,
    input  logic [AW-1:0]    rf_a3,
    input  logic [XLEN-1:0]  rf_wd,
    input  logic             stall,
    input  logic             flush,
    output logic [XLEN-1:0]  rd1_o,
    output logic [XLEN-1:0]  rd2_o,
    output logic [1:0]       npc_op_o,
    output logic [XLEN-1:0]  npc_o,
    output logic             is_jump_o,
    output logic             ex_valid_o,
    output logic [31:0]      ex_instr_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_rd1_o,
    output logic [XLEN-1:0]  ex_rd2_o,
    output logic [XLEN-1:0]  ex_imm_o,
    output logic [EXC_W-1:0] ex_exc_o,
    output logic             ex_bd_o
);

    logic [XLEN-1:0]  rf [NREG];
    logic [AW-1:0]    rsA, rtA;
    logic [31:0]      dInstr;
    logic [15:0]      imm16;
    logic [XLEN-1:0]  pc4, brTgt, jTgt, immExt;
    logic [EXC_W-1:0] excM;
    logic [1:0]       npcOp;
    extOp_e           extOp;
    logic             isJump, undef, wrHit, bdQ;

    assign rsA   = AW'(instr_i[25:21]);
    assign rtA   = AW'(instr_i[20:16]);
    assign wrHit = rf_we && (rf_a3 != '0);
    assign rd1_o = (wrHit && rf_a3 == rsA) ? rf_wd : rf[rsA];
    assign rd2_o = (wrHit && rf_a3 == rtA) ? rf_wd : rf[rtA];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wrHit) begin
            rf[rf_a3] <= rf_wd;
        end
    end

    // A bubble or an instruction already faulted in IF decodes as a nop.
    assign dInstr = (valid_i && exc_i == '0) ? instr_i : '0;
    assign imm16  = dInstr[15:0];

    id_decode uDecode (
        .op     (dInstr[31:26]),
        .rt     (dInstr[20:16]),
        .funct  (dInstr[5:0]),
        .rsEqRt (fwd_rd1_i == fwd_rd2_i),
        .rsLtz  (fwd_rd1_i[XLEN-1]),
        .rsEqz  (fwd_rd1_i == '0),
        .npcOp  (npcOp),
        .extOp  (extOp),
        .isJump (isJump),
        .undef  (undef)
    );

    assign pc4   = pc_i + XLEN'(4);
    assign brTgt = pc4 + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
    assign jTgt  = {pc4[XLEN-1:28], dInstr[25:0], 2'b00};

    always_comb begin
        case (npcOp)
            NPC_BR:  npc_o = brTgt;
            NPC_J:   npc_o = jTgt;
            NPC_JR:  npc_o = fwd_rd1_i;
            default: npc_o = pc4;
        endcase
    end

    assign npc_op_o  = stall ? NPC_SEQ : npcOp;
    assign is_jump_o = isJump;

    always_comb begin
        case (extOp)
            EXT_ZERO: immExt = XLEN'(imm16);
            EXT_LUI:  immExt = XLEN'({imm16, 16'h0000});
            default:  immExt = {{(XLEN-16){imm16[15]}}, imm16};
        endcase
    end

    assign excM = (exc_i != '0) ? exc_i :
                  (undef ? EXC_W'(EXC_RI) : '0);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ex_valid_o <= 1'b0;
            ex_instr_o <= '0;
            ex_pc_o    <= '0;
            ex_rd1_o   <= '0;
            ex_rd2_o   <= '0;
            ex_imm_o   <= '0;
            ex_exc_o   <= '0;
            ex_bd_o    <= 1'b0;
            bdQ        <= 1'b0;
        end else if (stall) begin
            // Bubble keeps PC and BD so an interrupt here still gets a correct EPC.
            ex_valid_o <= 1'b0;
            ex_instr_o <= '0;
            ex_pc_o    <= pc_i;
            ex_rd1_o   <= '0;
            ex_rd2_o   <= '0;
            ex_imm_o   <= '0;
            ex_exc_o   <= '0;
            ex_bd_o    <= bdQ;
        end else begin
            ex_valid_o <= valid_i;
            ex_instr_o <= (excM != '0) ? '0 : dInstr;
            ex_pc_o    <= pc_i;
            ex_rd1_o   <= fwd_rd1_i;
            ex_rd2_o   <= fwd_rd2_i;
            ex_imm_o   <= immExt;
            ex_exc_o   <= excM;
            ex_bd_o    <= bdQ;
            if (valid_i) bdQ <= isJump;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic
// against an instruction-level reference model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset, valid_i, rf_we, stall, flush;
    logic [31:0] instr_i, pc_i, fwd1, fwd2, rf_wd;
    logic [4:0]  exc_i, rf_a3;
    logic [31:0] rd1_o, rd2_o, npc_o;
    logic [1:0]  npc_op_o;
    logic        is_jump_o, ex_valid_o, ex_bd_o;
    logic [31:0] ex_instr_o, ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o;
    logic [4:0]  ex_exc_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] rfM [32];
    logic        bdM = 1'b0;

    localparam logic [5:0] OP_TAB [0:21] = '{
        6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h04,
        6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E,
        6'h0F, 6'h23, 6'h2B, 6'h20, 6'h3F, 6'h1C};
    localparam logic [5:0] FN_TAB [0:7] = '{
        6'h08, 6'h09, 6'h21, 6'h00, 6'h2A, 6'h27, 6'h10, 6'h05};
    localparam logic [31:0] VAL_TAB [0:4] = '{
        32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7, 32'h8000_0000};

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .instr_i(instr_i),
        .pc_i(pc_i), .exc_i(exc_i), .fwd_rd1_i(fwd1), .fwd_rd2_i(fwd2),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .stall(stall),
        .flush(flush), .rd1_o(rd1_o), .rd2_o(rd2_o), .npc_op_o(npc_op_o),
        .npc_o(npc_o), .is_jump_o(is_jump_o), .ex_valid_o(ex_valid_o),
        .ex_instr_o(ex_instr_o), .ex_pc_o(ex_pc_o), .ex_rd1_o(ex_rd1_o),
        .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o), .ex_exc_o(ex_exc_o),
        .ex_bd_o(ex_bd_o)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ISA-level meaning of one instruction word.
    task automatic isaRef(input logic [31:0] ins, input logic [31:0] pc,
                          input logic [31:0] r1, input logic [31:0] r2,
                          output logic [1:0] op, output logic [31:0] tgt,
                          output logic jmp, output logic und,
                          output logic [31:0] imm);
        int s1;
        logic taken;
        logic [31:0] pc4;
        s1    = int'(r1);
        pc4   = pc + 32'd4;
        op    = 2'd0;
        tgt   = 32'd0;
        jmp   = 1'b0;
        und   = 1'b0;
        taken = 1'b0;
        imm   = 32'(int'($signed(ins[15:0])));
        case (ins[31:26])
            6'h00: begin
                und = !(ins[5:0] inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06,
                        6'h07, 6'h08, 6'h09, 6'h2A, 6'h2B, [6'h20:6'h27]});
                if (ins[5:0] == 6'h08 || ins[5:0] == 6'h09) begin
                    jmp = 1'b1; op = 2'd3; tgt = r1;
                end
            end
            6'h01: begin
                if (ins[20:16] == 5'd0) begin jmp = 1'b1; taken = s1 < 0; end
                else if (ins[20:16] == 5'd1) begin jmp = 1'b1; taken = s1 >= 0; end
                else und = 1'b1;
            end
            6'h02, 6'h03: begin
                jmp = 1'b1; op = 2'd2;
                tgt = {pc4[31:28], ins[25:0], 2'b00};
            end
            6'h04: begin jmp = 1'b1; taken = r1 == r2; end
            6'h05: begin jmp = 1'b1; taken = r1 != r2; end
            6'h06: begin jmp = 1'b1; taken = s1 <= 0; end
            6'h07: begin jmp = 1'b1; taken = s1 > 0; end
            6'h0C, 6'h0D, 6'h0E: imm = {16'h0, ins[15:0]};
            6'h0F: imm = {ins[15:0], 16'h0};
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20, 6'h21, 6'h23, 6'h24,
            6'h25, 6'h28, 6'h29, 6'h2B: ;
            default: und = 1'b1;
        endcase
        if (taken) begin
            op  = 2'd1;
            tgt = pc4 + 32'(int'($signed(ins[15:0])) * 4);
        end
    endtask

    function automatic logic [31:0] rdRef(input logic [4:0] a);
        if (rf_we && rf_a3 != 0 && rf_a3 == a) return rf_wd;
        return rfM[a];
    endfunction

    task automatic step();
        logic [1:0]  op;
        logic [31:0] tgt, imm, ins;
        logic        jmp, und;
        logic [4:0]  excE;
        logic        eValid, eBd;
        logic [31:0] eInstr, ePc, eR1, eR2, eImm;
        logic [4:0]  eExc;
        @(negedge clk);
        ins = (valid_i && exc_i == 0) ? instr_i : 32'h0;
        isaRef(ins, pc_i, fwd1, fwd2, op, tgt, jmp, und, imm);
        if (stall) op = 2'd0;
        check("rd1", rd1_o, rdRef(instr_i[25:21]));
        check("rd2", rd2_o, rdRef(instr_i[20:16]));
        check("npcOp", 32'(npc_op_o), 32'(op));
        if (op != 0) check("npc", npc_o, tgt);
        check("isJump", 32'(is_jump_o), 32'(jmp));
        excE = (exc_i != 0) ? exc_i : (und ? 5'd10 : 5'd0);
        eValid = 0; eInstr = 0; ePc = 0; eR1 = 0; eR2 = 0;
        eImm = 0; eExc = 0; eBd = 0;
        if (reset || flush) begin
        end else if (stall) begin
            ePc = pc_i; eBd = bdM;
        end else begin
            eValid = valid_i;
            eInstr = (excE != 0) ? 32'h0 : ins;
            ePc = pc_i; eR1 = fwd1; eR2 = fwd2;
            eImm = imm; eExc = excE; eBd = bdM;
        end
        if (reset) begin
            foreach (rfM[i]) rfM[i] = 32'h0;
            bdM = 1'b0;
        end else begin
            if (rf_we && rf_a3 != 0) rfM[rf_a3] = rf_wd;
            if (flush) bdM = 1'b0;
            else if (!stall && valid_i) bdM = jmp;
        end
        @(posedge clk);
        #1;
        check("exValid", 32'(ex_valid_o), 32'(eValid));
        check("exInstr", ex_instr_o, eInstr);
        check("exPc", ex_pc_o, ePc);
        check("exRd1", ex_rd1_o, eR1);
        check("exRd2", ex_rd2_o, eR2);
        check("exImm", ex_imm_o, eImm);
        check("exExc", 32'(ex_exc_o), 32'(eExc));
        check("exBd", 32'(ex_bd_o), 32'(eBd));
    endtask

    task automatic idle();
        reset = 0; valid_i = 0; instr_i = 0; pc_i = 0; exc_i = 0;
        fwd1 = 0; fwd2 = 0; rf_we = 0; rf_a3 = 0; rf_wd = 0;
        stall = 0; flush = 0;
    endtask

    task automatic randInputs();
        logic [5:0] op;
        op = OP_TAB[$urandom_range(0, 21)];
        instr_i = $urandom;
        instr_i[31:26] = op;
        if (op == 6'h00 && $urandom_range(0, 3) != 0)
            instr_i[5:0] = FN_TAB[$urandom_range(0, 7)];
        if (op == 6'h01) instr_i[20:16] = 5'($urandom_range(0, 3));
        valid_i = $urandom_range(0, 99) < 85;
        exc_i   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        pc_i    = $urandom & 32'hFFFF_FFFC;
        fwd1    = $urandom_range(0, 1) ? VAL_TAB[$urandom_range(0, 4)] : $urandom;
        fwd2    = $urandom_range(0, 1) ? fwd1 : VAL_TAB[$urandom_range(0, 4)];
        rf_we   = $urandom_range(0, 1);
        rf_a3   = $urandom_range(0, 1) ? instr_i[25:21] : 5'($urandom);
        rf_wd   = $urandom;
        stall   = $urandom_range(0, 4) == 0;
        flush   = $urandom_range(0, 9) == 0;
        reset   = $urandom_range(0, 59) == 0;
    endtask

    initial begin
        foreach (rfM[i]) rfM[i] = 32'h0;
        idle();
        reset = 1; stall = 1;
        step();
        idle();

        rf_we = 1; rf_a3 = 5; rf_wd = 32'hDEAD; valid_i = 1;
        instr_i = {6'h00, 5'd5, 5'd0, 5'd1, 5'd0, 6'h21};
        #1 check("bypass", rd1_o, 32'hDEAD);
        step();
        rf_a3 = 0; rf_wd = 32'hFFFF;
        instr_i = {6'h00, 5'd0, 5'd5, 5'd1, 5'd0, 6'h21};
        #1 check("r0Byp", rd1_o, 32'h0);
        step();
        rf_we = 0;
        #1 check("r0Keep", rd1_o, 32'h0);
        check("r5Held", rd2_o, 32'hDEAD);
        step();

        pc_i = 32'h3000; fwd1 = 7; fwd2 = 7;
        instr_i = {6'h04, 5'd1, 5'd2, 16'hFFFF};
        #1 check("beqOp", 32'(npc_op_o), 32'd1);
        check("beqNpc", npc_o, 32'h3000);
        step();
        check("beqBd", 32'(ex_bd_o), 32'd0);
        pc_i = 32'h3004; instr_i = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
        step();
        check("slotBd", 32'(ex_bd_o), 32'd1);

        instr_i = 32'hFC00_0000;
        step();
        check("riExc", 32'(ex_exc_o), 32'd10);
        check("riInstr", ex_instr_o, 32'h0);
        exc_i = 4; instr_i = {6'h04, 5'd1, 5'd2, 16'h0004};
        #1 check("ifExcOp", 32'(npc_op_o), 32'd0);
        step();
        check("ifExc", 32'(ex_exc_o), 32'd4);
        exc_i = 0;

        pc_i = 32'h3010; instr_i = 32'h0060_0008; fwd1 = 32'h4000; stall = 1;
        #1 check("jrStallOp", 32'(npc_op_o), 32'd0);
        step();
        check("jrStallV", 32'(ex_valid_o), 32'd0);
        check("jrStallPc", ex_pc_o, 32'h3010);
        stall = 0;
        #1 check("jrOp", 32'(npc_op_o), 32'd3);
        check("jrNpc", npc_o, 32'h4000);
        step();
        check("jrV", 32'(ex_valid_o), 32'd1);

        pc_i = 32'h3020; instr_i = 32'h0C00_0100;
        step();
        flush = 1; stall = 1; pc_i = 32'h3024;
        step();
        check("flushV", 32'(ex_valid_o), 32'd0);
        check("flushBd", 32'(ex_bd_o), 32'd0);
        flush = 0; stall = 0; pc_i = 32'h3028;
        instr_i = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
        step();
        check("postFlushBd", 32'(ex_bd_o), 32'd0);

        for (int n = 0; n < 1500; n++) begin
            randInputs();
            step();
        end

        idle();
        reset = 1; stall = 1; valid_i = 1; pc_i = 32'h5000;
        step();
        reset = 0; stall = 0; valid_i = 0;
        for (int r = 0; r < 32; r++) begin
            instr_i = 32'(r) << 21;
            #1 check("rstRf", rd1_o, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
